// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// default register addresses, serializer states and status word layout.
package mmio_pkg;

  localparam logic [31:0] TXDATA_ADR_DEF = 32'h0000_FF00;
  localparam logic [31:0] STATUS_ADR_DEF = 32'h0000_FF04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_FULL_BIT    = 0;
  localparam int STAT_OVF_BIT     = 1;
  localparam int STAT_CNT_LSB     = 2;
  localparam int CTRL_CLR_OVF_BIT = 2;

  function automatic logic [31:0] pack_status(input logic [2:0] count,
                                              input logic       ovf,
                                              input logic       full);
    logic [31:0] w;
    w                       = '0;
    w[STAT_CNT_LSB +: 3]    = count;
    w[STAT_OVF_BIT]         = ovf;
    w[STAT_FULL_BIT]        = full;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO with wrap-around pointers and an occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module tx_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter snooping the processor store bus: data-register stores queue
// bytes in a 4-entry FIFO drained by an 8N1 serializer; status is readable.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] TXDATA_ADR   = TXDATA_ADR_DEF,
  parameter logic [31:0] STATUS_ADR   = STATUS_ADR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        tx_sel, st_sel;
  logic        push_req, pop, clr_ovf, ovf_set;
  logic [7:0]  fifo_dout;
  logic [2:0]  fifo_count;
  logic        fifo_full, fifo_empty;
  logic        unused_wdata;

  assign tx_sel       = (dataadr == TXDATA_ADR);
  assign st_sel       = (dataadr == STATUS_ADR);
  assign sel          = tx_sel | st_sel;
  assign push_req     = memwrite && tx_sel;
  assign clr_ovf      = memwrite && st_sel && writedata[CTRL_CLR_OVF_BIT];
  assign ovf_set      = push_req && fifo_full && !pop;
  assign readdata     = st_sel ? pack_status(fifo_count, ovf_q, fifo_full) : 32'h0;
  assign unused_wdata = ^writedata[31:8];
  assign tx           = tx_q;
  assign busy         = busy_q;

  tx_fifo #(
    .DEPTH  (4),
    .DATA_W (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (writedata[7:0]),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decided from the next state so tx comes straight off a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) || !fifo_empty || push_req;
    // A fresh overflow outranks a clear landing in the same cycle.
    ovf_d  = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized bench for mmio_uart_tx against a cycle-level
// behavioural model (byte queue plus remaining-frame-time counter).
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] TXA   = 32'h0000_FF00;
  localparam logic [31:0] STA   = 32'h0000_FF04;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .TXDATA_ADR   (TXA),
    .STATUS_ADR   (STA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel       (sel),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_fifo[$];
  logic [7:0] m_cur;
  int         m_left;
  bit         m_ovf;

  bit         txlog[$];
  logic [7:0] dec_b[$];
  int         dec_s[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_level(input logic [7:0] b, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[3'(slot - 1)];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] w;
    w      = '0;
    w[4:2] = 3'(m_fifo.size());
    w[1]   = m_ovf;
    w[0]   = (m_fifo.size() == 4);
    return w;
  endfunction

  function automatic bit exp_tx();
    return (m_left > 0) ? frame_level(m_cur, FRAME - m_left) : 1'b1;
  endfunction

  function automatic bit exp_busy();
    return (m_left > 0) || (m_fifo.size() > 0);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_left = 0;
    m_ovf  = 1'b0;
    m_cur  = 8'h00;
  endtask

  // One clock of bus activity: the serializer pops first, then the store lands.
  task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (m_left == 0 && m_fifo.size() > 0) begin
      m_cur  = m_fifo.pop_front();
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (we && a == STA && d[2]) m_ovf = 1'b0;
    if (we && a == TXA) begin
      if (m_fifo.size() < 4) m_fifo.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d);
    memwrite  = we;
    dataadr   = a;
    writedata = d;
    #1;
    chk("sel", 32'(sel), 32'((a == TXA) || (a == STA)));
    chk("readdata", readdata, (a == STA) ? exp_status() : 32'h0);
    model_step(we, a, d);
    @(posedge clk);
    #1;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(exp_busy()));
    txlog.push_back(tx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom & 32'h0000_0FFC, $urandom);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      idle(1);
      n++;
    end
    chk("drain_done", 32'(busy), 32'h0);
    idle(2);
  endtask

  task automatic decode();
    int i;
    logic [7:0] b;
    dec_b.delete();
    dec_s.delete();
    i = 0;
    while (i + FRAME <= txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB * (k + 1) + CPB / 2];
        dec_b.push_back(b);
        dec_s.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    memwrite = 1'b0;
    dataadr  = STA;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_bytes[$];
    int         n;
    int         bcnt;
    int         r;
    logic [31:0] a;

    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = STA;
    writedata = 32'h0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_status", readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    // Single byte: 0x155 stores 0x55, line 0,1,0,1,... held 4 cycles each.
    txlog.delete();
    cycle(1'b1, TXA, 32'h0000_0155);
    bcnt = busy ? 1 : 0;
    n    = 0;
    while (busy && n < 100) begin
      idle(1);
      if (busy) bcnt++;
      n++;
    end
    chk("t1_busy_len", 32'(bcnt), 32'd41);
    idle(3);
    decode();
    chk("t1_nframes", 32'(dec_b.size()), 32'd1);
    if (dec_b.size() > 0) begin
      chk("t1_byte", 32'(dec_b[0]), 32'h55);
      chk("t1_start_idx", 32'(dec_s[0]), 32'd1);
    end

    // Six stores into a four-deep FIFO while the first frame starts.
    txlog.delete();
    for (int i = 1; i <= 6; i++) cycle(1'b1, TXA, 32'(i));
    read_status("t2_status_ovf", 32'h0000_0013);
    cycle(1'b1, STA, 32'h0000_0004);
    read_status("t2_status_clr", 32'h0000_0011);
    drain(400);
    decode();
    chk("t2_nframes", 32'(dec_b.size()), 32'd5);
    for (int i = 0; i < dec_b.size() && i < 5; i++) chk("t2_byte", 32'(dec_b[i]), 32'(i + 1));

    // Push while full in the very cycle the serializer pops.
    txlog.delete();
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA5};
    for (int i = 0; i < 5; i++) cycle(1'b1, TXA, 32'(exp_bytes[i]));
    n = 0;
    while (!(m_left == 0 && m_fifo.size() == 4) && n < 100) begin
      idle(1);
      n++;
    end
    chk("t3_full_before", readdata & 32'h0, 32'h0);
    read_status("t3_full_prepop", 32'h0000_0011);
    cycle(1'b1, TXA, 32'hDEAD_BEA5);
    read_status("t3_status", 32'h0000_0011);
    drain(400);
    decode();
    chk("t3_nframes", 32'(dec_b.size()), 32'd6);
    for (int i = 0; i < dec_b.size() && i < 6; i++) chk("t3_byte", 32'(dec_b[i]), 32'(exp_bytes[i]));

    // Back-to-back frames: exactly one idle cycle between them.
    txlog.delete();
    cycle(1'b1, TXA, 32'h0000_0000);
    cycle(1'b1, TXA, 32'h0000_00FF);
    drain(200);
    decode();
    chk("t4_nframes", 32'(dec_b.size()), 32'd2);
    if (dec_b.size() == 2) begin
      chk("t4_byte0", 32'(dec_b[0]), 32'h00);
      chk("t4_byte1", 32'(dec_b[1]), 32'hFF);
      chk("t4_gap", 32'(dec_s[1] - dec_s[0]), 32'(FRAME + 1));
    end

    // Reset during data bit 3 with two bytes still queued.
    cycle(1'b1, TXA, 32'h0000_0081);
    cycle(1'b1, TXA, 32'h0000_0042);
    cycle(1'b1, TXA, 32'h0000_0024);
    n = 0;
    while (m_left != FRAME - (CPB * 4 + 1) && n < 200) begin
      idle(1);
      n++;
    end
    chk("t5_pre_tx", 32'(tx), 32'h0);
    reset = 1'b1;
    #1;
    chk("t5_rst_tx", 32'(tx), 32'h1);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    read_status("t5_status", 32'h0);
    txlog.delete();
    idle(60);
    decode();
    chk("t5_nframes", 32'(dec_b.size()), 32'd0);

    // Address decode.
    cycle(1'b1, 32'h0000_FF08, 32'h0000_0077);
    cycle(1'b1, 32'h0000_0000, 32'h0000_0077);
    read_status("t6_count", 32'h0);
    dataadr = TXA;
    #1;
    chk("t6_sel_tx", 32'(sel), 32'h1);
    chk("t6_rd_tx", readdata, 32'h0);
    dataadr = 32'h0000_FF08;
    #1;
    chk("t6_sel_ff08", 32'(sel), 32'h0);
    dataadr = 32'h0;
    #1;
    chk("t6_sel_zero", 32'(sel), 32'h0);
    dataadr = STA;
    #1;
    chk("t6_sel_st", 32'(sel), 32'h1);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       a = TXA;
        1:       a = STA;
        2:       a = 32'h0000_FF08;
        default: a = $urandom & 32'h0000_0FFC;
      endcase
      cycle(r < 4, a, $urandom);
    end
    drain(1000);
    read_status("t7_final_count", exp_status());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
